// File: rtl/core_ex_lsu_fsm_pkg.sv
// Shared encodings for the EX-stage load/store unit: access sizes, error codes,
// FSM states and the captured-op payload.
package core_ex_lsu_fsm_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_SIZE     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } lsu_state_e;

    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic       is_unsigned;
    } lsu_op_t;

    // Natural alignment check on the low address bits for a given access size.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            SZ_D:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_ex_lsu_fsm_align.sv
// Combinational lane steering: store data replication/shift and byte enables,
// plus load field extraction with sign/zero extension.
module core_ex_lsu_fsm_align
    import core_ex_lsu_fsm_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    localparam int unsigned MASK_W = XLEN / 8,
    localparam int unsigned OFF_W  = $clog2(MASK_W)
) (
    input  logic [1:0]        st_size,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   st_wdata,
    output logic [MASK_W-1:0] st_wmask,
    input  logic [1:0]        ld_size,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic              ld_unsigned,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0]   rep;
    logic [MASK_W-1:0] bytes;
    logic [XLEN-1:0]   field;
    logic [63:0]       f64;
    logic [63:0]       ext;
    logic              sx;

    // Store: replicate the element across the bus, then move it to its lane.
    always_comb begin
        rep   = st_data;
        bytes = '1;
        case (st_size)
            SZ_B: begin
                rep   = {MASK_W{st_data[7:0]}};
                bytes = MASK_W'(8'h01);
            end
            SZ_H: begin
                rep   = {(MASK_W / 2){st_data[15:0]}};
                bytes = MASK_W'(8'h03);
            end
            SZ_W: begin
                rep   = {(MASK_W / 4){st_data[31:0]}};
                bytes = MASK_W'(8'h0F);
            end
            default: begin
                rep   = st_data;
                bytes = MASK_W'(8'hFF);
            end
        endcase
        st_wdata = rep << {st_off, 3'b000};
        st_wmask = bytes << st_off;
    end

    // Load: extend in a 64-bit frame so one expression serves both widths.
    always_comb begin
        field = ld_rdata >> {ld_off, 3'b000};
        f64   = 64'(field);
        sx    = ~ld_unsigned;
        case (ld_size)
            SZ_B:    ext = {{56{sx & f64[7]}},  f64[7:0]};
            SZ_H:    ext = {{48{sx & f64[15]}}, f64[15:0]};
            SZ_W:    ext = {{32{sx & f64[31]}}, f64[31:0]};
            default: ext = f64;
        endcase
        ld_data = XLEN'(ext);
    end

endmodule

// File: rtl/core_ex_lsu_fsm.sv
// EX-stage load/store unit: accepts one op, issues a valid/ready memory request,
// waits for the response (with timeout) and hands back an extended result.
module core_ex_lsu_fsm
    import core_ex_lsu_fsm_pkg::*;
#(
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned TIMEOUT = 255,
    parameter  int unsigned TMO_W   = 8,
    localparam int unsigned MASK_W  = XLEN / 8,
    localparam int unsigned OFF_W   = $clog2(MASK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic              i_flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [XLEN-1:0]   o_rdata,
    output logic [1:0]        o_err
);

    lsu_state_e        state;
    lsu_op_t           op;
    logic [OFF_W-1:0]  off;
    logic [TMO_W-1:0]  cnt;
    logic              pending;

    logic              accept;
    logic              size_bad;
    logic              misal;
    logic              pend_now;
    logic [XLEN-1:0]   st_wdata;
    logic [MASK_W-1:0] st_wmask;
    logic [XLEN-1:0]   ld_data;

    assign accept   = valid_in & ready_in & (i_load | i_store) & ~i_flush;
    assign size_bad = (i_size == SZ_D) && (XLEN == 32);
    assign misal    = lsu_misaligned(i_size, i_addr[2:0]);
    // A late response landing while DONE is held already retires the timed-out request.
    assign pend_now = pending & ~mem_rsp_valid;

    core_ex_lsu_fsm_align #(.XLEN(XLEN)) u_align (
        .st_size     (i_size),
        .st_off      (i_addr[OFF_W-1:0]),
        .st_data     (i_wdata),
        .st_wdata    (st_wdata),
        .st_wmask    (st_wmask),
        .ld_size     (op.size),
        .ld_off      (off),
        .ld_unsigned (op.is_unsigned),
        .ld_rdata    (mem_rsp_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ready_in      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            valid_out     <= 1'b0;
            o_rdata       <= '0;
            o_err         <= ERR_NONE;
            cnt           <= '0;
            pending       <= 1'b0;
            op            <= '0;
            off           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op       <= '{is_load: i_load, size: i_size, is_unsigned: i_unsigned};
                        off      <= i_addr[OFF_W-1:0];
                        ready_in <= 1'b0;
                        if (size_bad || misal) begin
                            state     <= S_DONE;
                            valid_out <= 1'b1;
                            o_rdata   <= '0;
                            o_err     <= size_bad ? ERR_SIZE : ERR_MISALIGN;
                        end else begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {i_addr[XLEN-1:OFF_W], OFF_W'(0)};
                            mem_req_wen   <= i_store;
                            mem_req_wdata <= i_store ? st_wdata : '0;
                            mem_req_wmask <= i_store ? st_wmask : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        // A flush coinciding with the handshake still owes a response.
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= i_flush ? S_DRAIN : S_WAIT;
                    end else if (i_flush) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_IDLE;
                        ready_in      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_flush) begin
                        state    <= mem_rsp_valid ? S_IDLE : S_DRAIN;
                        ready_in <= mem_rsp_valid;
                    end else if (mem_rsp_valid) begin
                        state     <= S_DONE;
                        valid_out <= 1'b1;
                        o_rdata   <= op.is_load ? ld_data : '0;
                        o_err     <= ERR_NONE;
                    end else if ((TIMEOUT != 0) && (cnt == TMO_W'(TIMEOUT))) begin
                        state     <= S_DONE;
                        valid_out <= 1'b1;
                        o_rdata   <= '0;
                        o_err     <= ERR_TIMEOUT;
                        pending   <= 1'b1;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    if (i_flush || ready_out) begin
                        valid_out <= 1'b0;
                        o_rdata   <= '0;
                        o_err     <= ERR_NONE;
                        pending   <= 1'b0;
                        state     <= pend_now ? S_DRAIN : S_IDLE;
                        ready_in  <= ~pend_now;
                    end else if (mem_rsp_valid) begin
                        pending <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) begin
                        state    <= S_IDLE;
                        ready_in <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ready_in <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/core_ex_lsu_fsm.md
Name: core_ex_lsu_fsm

Overview:
- Parametrised, handshaked load/store unit for the EX stage; successor to the fixed-latency, 32-bit-only DPI-style LSU.
- Accepts one memory op per transaction from the execute control: address from ALU result, store data from rs2.
- Drives a valid/ready request/response memory port, aligns store data and byte masks, and sign/zero-extends load data.
- Supports flush-cancel, misalignment/size errors and a response timeout; XLEN is selectable (32 or 64).

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 255, maximum cycles in WAIT before an error completion; 0 disables the timeout.
- TMO_W, 8, timeout counter width; requirement: 2^TMO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  op offered by EX control.
- ready_in  out  1  LSU can accept an op.
- i_load  in  1  op is a load.
- i_store  in  1  op is a store; i_load and i_store are never both 1.
- i_size  in  2  0=byte, 1=half, 2=word, 3=double.
- i_unsigned  in  1  zero-extend the load result.
- i_addr  in  XLEN  effective address.
- i_wdata  in  XLEN  store data, LSB-justified.
- i_flush  in  1  pipeline flush; cancels the in-flight op.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  address aligned down to XLEN/8 bytes.
- mem_req_wen  out  1  1 = write.
- mem_req_wdata  out  XLEN  lane-aligned store data.
- mem_req_wmask  out  XLEN/8  byte enables.
- mem_rsp_valid  in  1  response (read data or write ack) valid.
- mem_rsp_rdata  in  XLEN  read data, full bus word.
- valid_out  out  1  result available.
- ready_out  in  1  writeback consumes the result.
- o_rdata  out  XLEN  extended load data; 0 for stores and errors.
- o_err  out  2  0=none, 1=misaligned, 2=illegal size, 3=timeout.

Behaviour:
- Reset: state IDLE, ready_in=1, mem_req_valid=0, valid_out=0, o_rdata=0, o_err=0, timeout counter=0. Reset is taken mid-transaction too, abandoning any outstanding request.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- ready_in = (state==IDLE). An op is accepted on valid_in & ready_in & (i_load|i_store). All op fields are registered at accept; outputs depend only on registered values.
- Accept from IDLE:
  - Illegal size (size 3 with XLEN=32) -> DONE, o_err=2.
  - Misaligned (half with addr[0]; word with addr[1:0]!=0; double with addr[2:0]!=0) -> DONE, o_err=1.
  - Otherwise -> REQ.
  - Error completion has 1-cycle latency and generates no memory request.
- REQ:
  - mem_req_valid=1; request fields are held stable until mem_req_ready.
  - On handshake -> WAIT, counter cleared.
  - Earliest response is the cycle after the request handshake.
- WAIT:
  - Counter increments each cycle.
  - mem_rsp_valid -> DONE with o_rdata computed and o_err=0.
  - Counter==TIMEOUT (TIMEOUT!=0) -> DONE, o_err=3; a late response is then absorbed through DRAIN on the next transaction boundary. Implement this with a sticky pending flag.
- DONE: valid_out=1 and held with data until ready_out; on handshake -> IDLE.
- Flush:
  - In REQ before the handshake -> IDLE; no request is issued.
  - If the handshake and the flush occur in the same cycle, the request counts as issued -> DRAIN.
  - In WAIT -> DRAIN.
  - In DONE -> IDLE, with valid_out dropped the next cycle.
  - A flush in IDLE has no effect. An accept and a flush in the same cycle: the flush wins and nothing is accepted.
- DRAIN: waits for mem_rsp_valid, discards it, -> IDLE. ready_in=0 throughout.
- Store lane alignment:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_req_wdata = replicated element shifted left by off*8.
  - mem_req_wmask = ((1<<(1<<size))-1) << off.
  - Loads drive wmask=0.
- Load extraction:
  - Field = mem_rsp_rdata >> off*8, truncated to 8<<size bits.
  - Sign-extended unless i_unsigned; word loads sign-extend to 64 when XLEN=64.
- Peak throughput: one op per 4 cycles (accept, REQ, rsp, DONE) with zero-wait memory.

Decomposition:
- Shared package/defines (core_defines): size encodings, error codes, state encodings, LSU_XLEN-derived MASK_W.
- One natural sub-module: core_lsu_align (combinational), covering store lane/mask generation and load extract/extend. The FSM, counter and registers stay in the top.

Test Plan:
- XLEN=32, store word 0xDEADBEEF @0x1004, mem_req_ready after 2 cycles:
  - mem_req_addr=0x1004, wmask=4'b1111, wdata=0xDEADBEEF.
  - Ack -> valid_out with o_err=0, o_rdata=0.
- Load byte signed @0x1003, rdata=0x80112233 -> o_rdata=0xFFFFFF80. Same with i_unsigned -> 0x00000080.
- Load half @0x2001 -> no mem_req_valid; valid_out next cycle with o_err=1.
- XLEN=64, size 3 @0x8 -> wmask=8'hFF. XLEN=32, size 3 -> o_err=2.
- Flush in WAIT, response 3 cycles later:
  - State DRAIN, ready_in=0, no valid_out.
  - ready_in returns 1 the cycle after the response.
- TIMEOUT=4, no response -> valid_out with o_err=3 exactly 5 cycles after the request handshake. ready_out held low for 3 cycles -> outputs stable.
